// File: rtl/addr_burst_arbiter_pkg.sv
// Shared types and default sizing for the address burst arbiter.
package addr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int ARB_NREQ      = 4;
    localparam int ARB_BURST_LEN = 4;
    localparam int ARB_AW        = 4;
    localparam int ARB_IDW       = $clog2(ARB_NREQ);

endpackage

// File: rtl/addr_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo NREQ.
module rr_pick
    import addr_arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    parameter int IDW  = ARB_IDW
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IDW-1:0]  o_id,
    output logic            o_any
);

    // Scan distances 0..NREQ-1 from the pointer; the inner loop keeps every
    // bit select constant so NREQ need not be a power of two.
    always_comb begin
        int v_idx;
        o_onehot = '0;
        o_id     = '0;
        o_any    = 1'b0;
        v_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = (int'(i_ptr) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!o_any && (i == v_idx) && i_req[i]) begin
                    o_onehot[i] = 1'b1;
                    o_id        = IDW'(i);
                    o_any       = 1'b1;
                end else begin
                    o_any = o_any;
                end
            end
        end
    end

endmodule

// File: rtl/addr_burst_arbiter.sv
// Round-robin arbiter that grants one requester and then walks BURST_LEN
// addresses through its window under a valid/ready handshake.
module addr_burst_arbiter
    import addr_arb_pkg::*;
#(
    parameter int NREQ      = ARB_NREQ,
    parameter int BURST_LEN = ARB_BURST_LEN,
    parameter int AW        = ARB_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            addr_ready,
    output logic [NREQ-1:0] gnt,
    output logic [AW-1:0]   result,
    output logic            addr_valid,
    output logic            last,
    output logic            busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int OW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    arb_state_e      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [OW-1:0]   r_offset;
    logic [NREQ-1:0] r_gnt;
    logic [AW-1:0]   r_result;
    logic            r_addr_valid;
    logic            r_last;
    logic            r_busy;

    logic [NREQ-1:0] w_onehot;
    logic [IDW-1:0]  w_id;
    logic            w_any;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_id     (w_id),
        .o_any    (w_any)
    );

    // Arbitration / burst FSM with all outputs held in registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_offset     <= '0;
            r_gnt        <= '0;
            r_result     <= '0;
            r_addr_valid <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt        <= w_onehot;
                        r_result     <= AW'(int'(w_id) * BURST_LEN);
                        r_offset     <= '0;
                        r_addr_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_last       <= (BURST_LEN == 1) ? 1'b1 : 1'b0;
                        r_ptr        <= IDW'((int'(w_id) + 1) % NREQ);
                        r_state      <= BURST;
                    end else begin
                        r_gnt        <= '0;
                        r_result     <= '0;
                        r_offset     <= '0;
                        r_addr_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_last       <= 1'b0;
                    end
                end
                BURST: begin
                    // r_last marks the final beat, so its handshake closes the burst.
                    if (r_addr_valid && addr_ready) begin
                        if (r_last) begin
                            r_gnt        <= '0;
                            r_result     <= '0;
                            r_offset     <= '0;
                            r_addr_valid <= 1'b0;
                            r_busy       <= 1'b0;
                            r_last       <= 1'b0;
                            r_state      <= IDLE;
                        end else begin
                            r_offset <= r_offset + OW'(1);
                            r_result <= r_result + AW'(1);
                            r_last   <= ((int'(r_offset) + 1) == (BURST_LEN - 1)) ? 1'b1 : 1'b0;
                        end
                    end else begin
                        r_offset <= r_offset;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign result     = r_result;
    assign addr_valid = r_addr_valid;
    assign last       = r_last;
    assign busy       = r_busy;

endmodule

// File: tb/tb_addr_burst_arbiter.sv
// Directed self-checking bench: a default 4x4 instance plus a 2-requester,
// single-beat instance sharing clock and reset.
module tb_addr_burst_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       addr_ready;
    logic [3:0] gnt;
    logic [3:0] result;
    logic       addr_valid;
    logic       last;
    logic       busy;

    logic [1:0] req2;
    logic       addr_ready2;
    logic [1:0] gnt2;
    logic [3:0] result2;
    logic       addr_valid2;
    logic       last2;
    logic       busy2;

    int n_checks;
    int n_fail;
    int n_hs;

    addr_burst_arbiter #(.NREQ(4), .BURST_LEN(4), .AW(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .addr_ready (addr_ready),
        .gnt        (gnt),
        .result     (result),
        .addr_valid (addr_valid),
        .last       (last),
        .busy       (busy)
    );

    addr_burst_arbiter #(.NREQ(2), .BURST_LEN(1), .AW(4)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .req        (req2),
        .addr_ready (addr_ready2),
        .gnt        (gnt2),
        .result     (result2),
        .addr_valid (addr_valid2),
        .last       (last2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " gnt"},   32'(gnt), 32'd0);
        check_eq({tag, " valid"}, 32'(addr_valid), 32'd0);
        check_eq({tag, " result"}, 32'(result), 32'd0);
        check_eq({tag, " last"},  32'(last), 32'd0);
        check_eq({tag, " busy"},  32'(busy), 32'd0);
    endtask

    task automatic check_beat(input string tag, input logic [3:0] e_gnt,
                              input logic [3:0] e_res, input logic e_last);
        check_eq({tag, " gnt"},    32'(gnt), 32'(e_gnt));
        check_eq({tag, " valid"},  32'(addr_valid), 32'd1);
        check_eq({tag, " result"}, 32'(result), 32'(e_res));
        check_eq({tag, " last"},   32'(last), 32'(e_last));
        check_eq({tag, " busy"},   32'(busy), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    logic [3:0] ready_pat [6] = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
    logic [3:0] res_pat   [6] = '{4'd5, 4'd5, 4'd5, 4'd6, 4'd7, 4'd0};
    logic       last_pat  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        n_hs        = 0;
        rst         = 1'b0;
        req         = 4'd0;
        addr_ready  = 1'b0;
        req2        = 2'd0;
        addr_ready2 = 1'b0;
        #1;

        // Reset and quiet idle.
        do_reset();
        check_idle("reset");
        for (int c = 0; c < 5; c++) begin
            step();
            check_idle("idle_noreq");
        end

        // Single pulsed request from requester 2.
        req = 4'b0100;
        addr_ready = 1'b1;
        step();
        req = 4'b0000;
        check_beat("pulse b0", 4'b0100, 4'd8, 1'b0);
        step();
        check_beat("pulse b1", 4'b0100, 4'd9, 1'b0);
        step();
        check_beat("pulse b2", 4'b0100, 4'd10, 1'b0);
        step();
        check_beat("pulse b3", 4'b0100, 4'd11, 1'b1);
        step();
        check_idle("pulse end");

        // All requesting: rotation 0,1,2,3,0 with an idle bubble between bursts.
        do_reset();
        req = 4'b1111;
        addr_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            logic [3:0] gi;
            gi = 4'(g % 4);
            for (int b = 0; b < 4; b++) begin
                step();
                check_beat("rr beat", 4'b0001 << gi, 4'(gi * 4 + 4'(b)), (b == 3));
            end
            step();
            check_idle("rr bubble");
            if (g == 4) begin
                req = 4'b0000;
            end else begin
                req = 4'b1111;
            end
        end

        // Requester 1 with a stalling consumer.
        req = 4'b0010;
        addr_ready = 1'b0;
        step();
        req = 4'b0000;
        check_beat("stall b0", 4'b0010, 4'd4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            addr_ready = ready_pat[i][0];
            if (addr_valid && addr_ready) n_hs++;
            step();
            check_eq("stall result", 32'(result), 32'(res_pat[i]));
            check_eq("stall last", 32'(last), 32'(last_pat[i]));
        end
        check_eq("stall valid end", 32'(addr_valid), 32'd0);
        check_eq("stall handshakes", 32'(n_hs), 32'd4);

        // Reset during third beat of requester 3's burst.
        do_reset();
        addr_ready = 1'b1;
        req = 4'b1000;
        step();
        req = 4'b0000;
        check_beat("abort b0", 4'b1000, 4'd12, 1'b0);
        step();
        step();
        check_beat("abort b2", 4'b1000, 4'd14, 1'b0);
        rst = 1'b0;
        step();
        check_idle("abort rst");
        rst = 1'b1;
        req = 4'b0001;
        step();
        req = 4'b0000;
        check_beat("after abort", 4'b0001, 4'd0, 1'b0);
        for (int b = 0; b < 4; b++) step();
        check_idle("after abort end");

        // Two requesters, single-beat bursts.
        req2 = 2'b11;
        addr_ready2 = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step();
            check_eq("bl1 gnt", 32'(gnt2), (g % 2 == 0) ? 32'd1 : 32'd2);
            check_eq("bl1 result", 32'(result2), (g % 2 == 0) ? 32'd0 : 32'd1);
            check_eq("bl1 last", 32'(last2), 32'd1);
            check_eq("bl1 valid", 32'(addr_valid2), 32'd1);
            step();
            check_eq("bl1 bubble", 32'(addr_valid2), 32'd0);
        end
        req2 = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
